keypad_bcd_calc: RTL

Parametrised successor to the fixed 3-digit keypad adder: the block takes raw 4-bit keypad samples, debounces them, and assembles two BCD operands of `DIGITS` digits each. It then computes A+B or |A−B| with a digit-serial BCD datapath and drives a `DIGITS+1`-digit BCD display word plus a sign flag. It sits between the keypad scanner and the 7-segment display driver.

---
 rtl/keypad_bcd_calc_pkg.sv | 69 ++++++
 rtl/keypad_bcd_calc_if.sv | 11 +
 rtl/keypad_bcd_calc_key_debounce.sv | 71 +++++++
 rtl/keypad_bcd_calc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_bcd_calc_pkg.sv
// Shared key codes, FSM/op enums and single-digit BCD arithmetic for the keypad calculator.
package keypad_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_EQ   = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_DIGIT = 3'd1,
    K_OP    = 3'd2,
    K_EQ    = 3'd3,
    K_CLR   = 3'd4
  } kind_t;

  function automatic kind_t classify(input logic [3:0] code);
    case (code)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9: classify = K_DIGIT;
      KEY_ADD, KEY_SUB:             classify = K_OP;
      KEY_EQ:                       classify = K_EQ;
      KEY_CLR:                      classify = K_CLR;
      default:                      classify = K_NONE;
    endcase
  endfunction

  // Returns {carry, digit}; +6 folds a binary sum above 9 back into BCD.
  function automatic logic [4:0] bcd_add_digit(input logic [3:0] a, input logic [3:0] b,
                                               input logic cin);
    logic [4:0] s;
    logic [4:0] t;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    t = s + 5'd6;
    if (s > 5'd9) begin
      bcd_add_digit = {1'b1, t[3:0]};
    end else begin
      bcd_add_digit = {1'b0, s[3:0]};
    end
  endfunction

  // Returns {borrow, digit}; a negative 5-bit difference means borrow, then -6 mod 16.
  function automatic logic [4:0] bcd_sub_digit(input logic [3:0] a, input logic [3:0] b,
                                               input logic bin);
    logic [4:0] d;
    logic [3:0] t;
    d = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
    t = d[3:0] - 4'd6;
    if (d[4]) begin
      bcd_sub_digit = {1'b1, t};
    end else begin
      bcd_sub_digit = {1'b0, d[3:0]};
    end
  endfunction

endpackage

// File: rtl/keypad_bcd_calc_if.sv
// Keypad-sample in, display word/status out; the calculator is the slave side.
interface keypad_bcd_calc_if #(parameter int DIGITS = 3);
  logic [3:0]              sample;
  logic [4*(DIGITS+1)-1:0] cdu;
  logic                    neg;
  logic                    done;
  logic                    busy;

  modport master (output sample, input cdu, neg, done, busy);
  modport slave  (input sample, output cdu, neg, done, busy);
endinterface

// File: rtl/keypad_bcd_calc_key_debounce.sv
// Accepts a key once after DEBOUNCE identical samples; re-arms after DEBOUNCE idle samples.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sample,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [3:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          valid_q, valid_d;
  logic [3:0]    code_q, code_d;
  logic          hit;

  // Run-length of the current sample; hit marks the edge the run first reaches DEBOUNCE.
  always_comb begin
    last_d  = sample;
    cnt_d   = cnt_q;
    hit     = 1'b0;
    armed_d = armed_q;
    valid_d = 1'b0;
    code_d  = code_q;
    if (sample != last_q) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
      hit   = (cnt_d == CNT_MAX);
    end
    if (hit && (sample == KEY_NONE)) begin
      armed_d = 1'b1;
    end else if (hit && armed_q) begin
      armed_d = 1'b0;
      valid_d = 1'b1;
      code_d  = sample;
    end else begin
      armed_d = armed_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= KEY_NONE;
      cnt_q   <= {CW{1'b0}};
      armed_q <= 1'b1;
      valid_q <= 1'b0;
      code_q  <= KEY_NONE;
    end else begin
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: rtl/keypad_bcd_calc.sv
// Keypad BCD calculator: operand entry FSM plus a digit-serial BCD add/|sub| unit.
module keypad_bcd_calc
  import keypad_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int DEBOUNCE = 8
) (
  input logic               clk,
  input logic               rst,
  keypad_bcd_calc_if.slave  bus
);

  localparam int OW = 4 * DIGITS;
  localparam int RW = 4 * (DIGITS + 1);
  localparam int IW = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS);

  logic          key_valid;
  logic [3:0]    key_code;
  kind_t         kind;
  logic          do_clear;
  logic [4:0]    dig;

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [OW-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0] count_q, count_d, idx_q, idx_d;
  logic          carry_q, carry_d, sign_q, sign_d;
  logic [RW-1:0] cdu_q, cdu_d;
  logic          neg_q, neg_d, done_q, done_d, busy_q, busy_d;

  function automatic logic [OW-1:0] shift_in(input logic [OW-1:0] v, input logic [3:0] d);
    logic [OW-1:0] t;
    t      = v << 3'd4;
    t[3:0] = d;
    return t;
  endfunction

  function automatic logic [OW-1:0] push_msd(input logic [OW-1:0] v, input logic [3:0] d);
    logic [OW-1:0] t;
    t           = v >> 3'd4;
    t[OW-1 -: 4] = d;
    return t;
  endfunction

  function automatic logic [RW-1:0] zext(input logic [OW-1:0] v);
    return {4'h0, v};
  endfunction

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .sample    (bus.sample),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  // Next-state: clear overrides everything outside CALC; CALC ignores keys.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    count_d = count_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    cdu_d   = cdu_q;
    neg_d   = neg_q;
    dig     = 5'd0;
    kind     = key_valid ? classify(key_code) : K_NONE;
    do_clear = (kind == K_CLR) && (state_q != CALC);
    if (do_clear) begin
      state_d = ENTER_A;
      op_d    = OP_ADD;
      a_d     = {OW{1'b0}};
      b_d     = {OW{1'b0}};
      count_d = {IW{1'b0}};
      sign_d  = 1'b0;
      cdu_d   = {RW{1'b0}};
      neg_d   = 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          case (kind)
            K_DIGIT: begin
              a_d     = shift_in(a_q, key_code);
              count_d = count_q + IW'(1);
              cdu_d   = zext(a_d);
              if (count_d >= LAST) begin
                state_d = ENTER_B;
                count_d = {IW{1'b0}};
                op_d    = OP_ADD;
              end else begin
                state_d = ENTER_A;
              end
            end
            K_OP: begin
              op_d    = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
              count_d = {IW{1'b0}};
              state_d = ENTER_B;
            end
            default: state_d = ENTER_A;
          endcase
        end
        // cdu keeps showing A until the first B digit arrives.
        ENTER_B: begin
          case (kind)
            K_DIGIT: begin
              b_d     = shift_in(b_q, key_code);
              count_d = count_q + IW'(1);
              cdu_d   = zext(b_d);
              if (count_d >= LAST) begin
                state_d = CALC;
                count_d = {IW{1'b0}};
                idx_d   = {IW{1'b0}};
              end else begin
                state_d = ENTER_B;
              end
            end
            K_OP: begin
              if (count_q == {IW{1'b0}}) begin
                op_d = (key_code == KEY_SUB) ? OP_SUB : OP_ADD;
              end else begin
                op_d = op_q;
              end
            end
            K_EQ: begin
              state_d = CALC;
              count_d = {IW{1'b0}};
              idx_d   = {IW{1'b0}};
            end
            default: state_d = ENTER_B;
          endcase
        end
        CALC: begin
          if (idx_q == {IW{1'b0}}) begin
            if ((op_q == OP_SUB) && (a_q < b_q)) begin
              a_d    = b_q;
              b_d    = a_q;
              sign_d = 1'b1;
            end else begin
              sign_d = 1'b0;
            end
            carry_d = 1'b0;
            sum_d   = {OW{1'b0}};
            idx_d   = IW'(1);
          end else begin
            if (op_q == OP_ADD) begin
              dig = bcd_add_digit(a_q[3:0], b_q[3:0], carry_q);
            end else begin
              dig = bcd_sub_digit(a_q[3:0], b_q[3:0], carry_q);
            end
            a_d     = a_q >> 3'd4;
            b_d     = b_q >> 3'd4;
            sum_d   = push_msd(sum_q, dig[3:0]);
            carry_d = dig[4];
            if (idx_q == LAST) begin
              state_d = SHOW;
              idx_d   = {IW{1'b0}};
              cdu_d   = {3'b000, dig[4], sum_d};
              neg_d   = sign_q;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        SHOW: begin
          if (kind == K_DIGIT) begin
            a_d     = shift_in({OW{1'b0}}, key_code);
            b_d     = {OW{1'b0}};
            count_d = IW'(1);
            op_d    = OP_ADD;
            cdu_d   = zext(a_d);
            neg_d   = 1'b0;
            state_d = ENTER_A;
          end else begin
            state_d = SHOW;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end
    busy_d = (state_d == CALC);
    done_d = (state_q == CALC) && (state_d == SHOW);
  end

  // All state and outputs registered; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENTER_A;
      op_q    <= OP_ADD;
      a_q     <= {OW{1'b0}};
      b_q     <= {OW{1'b0}};
      sum_q   <= {OW{1'b0}};
      count_q <= {IW{1'b0}};
      idx_q   <= {IW{1'b0}};
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      cdu_q   <= {RW{1'b0}};
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      cdu_q   <= cdu_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cdu  = cdu_q;
  assign bus.neg  = neg_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

endmodule
